// File: rtl/imem_pkg.sv
// Shared constants for the programmable instruction memory: FSM encodings,
// default fill word and bytes per instruction word.
package imem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef logic [1:0] state_t;

    localparam state_t ST_CLEAR = 2'd0;
    localparam state_t ST_READY = 2'd1;
    localparam state_t ST_LOAD  = 2'd2;
    localparam state_t ST_FLUSH = 2'd3;

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH_WORDS x 32 synchronous RAM, one write port and one read port.
// The array has no reset; it is refilled by the owner after reset.
module imem_ram_1r1w #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // read port, output register only updates on a read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_prog_fetch.sv
// Programmable instruction memory. After reset the array is filled with
// NOP_INSTR, then the core fetches through a 1-cycle registered port. A boot
// loader can reload it from a little-endian byte stream while prog_en is high.
//
// state | meaning
// CLEAR | writing NOP_INSTR to every word, one per cycle
// READY | fetch port open, waiting for prog_en
// LOAD  | accepting stream bytes, assembling and writing words
// FLUSH | writing any partial word zero-filled, pulsing prog_done
module imem_prog_fetch
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [7:0]        prog_byte,
    output logic              prog_ready,
    output logic              prog_done,
    output logic              prog_err,
    output logic              fetch_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]   PTR_FULL    = PW'(DEPTH_WORDS);
    localparam logic [PW-1:0]   PTR_LAST    = PW'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W:0] FETCH_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * WORD_BYTES);

    state_t        state;
    logic [PW-1:0] clr_ptr;
    logic [PW-1:0] wr_ptr;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_word;
    logic          sel_nop;

    logic          prog_acc;
    logic          prog_full;
    logic          fetch_acc;
    logic          fetch_bad;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign fetch_ready = (state == ST_READY);
    assign prog_ready  = (state == ST_LOAD) && prog_en;
    assign prog_done   = (state == ST_FLUSH);
    assign prog_acc    = prog_valid && prog_ready;
    assign prog_full   = (wr_ptr == PTR_FULL);
    assign fetch_acc   = fetch_req && fetch_ready;
    // compare one bit wider so the range check covers the full address
    assign fetch_bad   = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= FETCH_LIMIT);
    assign fetch_instr = sel_nop ? NOP_INSTR : ram_rdata;

    // RAM write-port mux: clear fill, completed word, or flushed partial word
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = NOP_INSTR;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr[AW-1:0];
                ram_wdata = NOP_INSTR;
            end
            ST_LOAD: begin
                if (prog_acc && !prog_full && (byte_cnt == 2'd3)) begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_ptr[AW-1:0];
                    ram_wdata = {prog_byte, asm_word[23:0]};
                end
            end
            ST_FLUSH: begin
                if (byte_cnt != 2'd0) begin
                    ram_we    = 1'b1;
                    ram_waddr = wr_ptr[AW-1:0];
                    ram_wdata = asm_word;
                end
            end
            default: ;
        endcase
    end

    // sequencing FSM, pointers and byte assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            wr_ptr   <= '0;
            byte_cnt <= 2'd0;
            asm_word <= '0;
            prog_err <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == PTR_LAST) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (prog_en) begin
                        state    <= ST_LOAD;
                        wr_ptr   <= '0;
                        byte_cnt <= 2'd0;
                        prog_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!prog_en) begin
                        state <= ST_FLUSH;
                    end else if (prog_acc) begin
                        if (prog_full) begin
                            // overflow: drop the byte but keep accepting
                            prog_err <= 1'b1;
                        end else begin
                            case (byte_cnt)
                                // lane 0 clears the upper lanes so a flush is zero-filled
                                2'd0:    asm_word <= {24'h0, prog_byte};
                                2'd1:    asm_word[15:8]  <= prog_byte;
                                2'd2:    asm_word[23:16] <= prog_byte;
                                default: wr_ptr <= wr_ptr + 1'b1;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state    <= ST_READY;
                    byte_cnt <= 2'd0;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // fetch response registers; fetch_instr holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            sel_nop     <= 1'b1;
        end else begin
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fetch_fault <= fetch_bad;
                sel_nop     <= fetch_bad;
            end
        end
    end

    imem_ram_1r1w #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (fetch_acc && !fetch_bad),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_imem_prog_fetch.sv
// Bench for imem_prog_fetch: fetch results go through a scoreboard queue,
// control outputs are checked directly against hand-computed values.
module tb_imem_prog_fetch;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_en;
    logic        prog_valid;
    logic [7:0]  prog_byte;
    logic        prog_ready;
    logic        prog_done;
    logic        prog_err;
    logic        fetch_ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    int n_chk  = 0;
    int n_fail = 0;
    int n_valid = 0;
    logic [32:0] sb [$];
    logic [7:0]  pbuf [$];
    logic        rdy_low;

    imem_prog_fetch #(.DEPTH_WORDS(DEPTH), .ADDR_W(32), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_en     (prog_en),
        .prog_valid  (prog_valid),
        .prog_byte   (prog_byte),
        .prog_ready  (prog_ready),
        .prog_done   (prog_done),
        .prog_err    (prog_err),
        .fetch_ready (fetch_ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (fetch_valid) begin
            logic [32:0] e;
            n_valid++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_fetch_valid: got instr 0x%08h with no request outstanding at %0t",
                         fetch_instr, $time);
            end else begin
                e = sb.pop_front();
                check("fetch_instr", fetch_instr, e[31:0]);
                check("fetch_fault", {31'h0, fetch_fault}, {31'h0, e[32]});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!fetch_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!fetch_ready) check("fetch_ready_timeout", 32'(fetch_ready), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
        wait_ready();
        fetch_req  = 1'b1;
        fetch_addr = a;
        sb.push_back({ef, ei});
        tick();
        fetch_req  = 1'b0;
    endtask

    task automatic load_buf();
        wait_ready();
        prog_en = 1'b1;
        tick();
        check("prog_ready_in_load", 32'(prog_ready), 32'd1);
        check("prog_err_cleared", 32'(prog_err), 32'd0);
        rdy_low = 1'b0;
        foreach (pbuf[i]) begin
            prog_valid = 1'b1;
            prog_byte  = pbuf[i];
            if (!prog_ready) rdy_low = 1'b1;
            tick();
        end
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        tick();
        check("prog_done_pulse", 32'(prog_done), 32'd1);
        tick();
        check("prog_done_low", 32'(prog_done), 32'd0);
        check("ready_after_flush", 32'(fetch_ready), 32'd1);
    endtask

    task automatic clear_wait();
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            if (k == DEPTH - 1) check("fetch_ready_early", 32'(fetch_ready), 32'd0);
        end
        check("fetch_ready_at_depth", 32'(fetch_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        rst = 1'b1; prog_en = 1'b0; prog_valid = 1'b0; prog_byte = 8'h00;
        fetch_req = 1'b0; fetch_addr = '0;
        repeat (3) tick();

        // 1: reset values and clear duration
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_prog_ready", 32'(prog_ready), 32'd0);
        check("rst_prog_done", 32'(prog_done), 32'd0);
        check("rst_prog_err", 32'(prog_err), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_instr", fetch_instr, NOP);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        rst = 1'b0;
        clear_wait();
        do_fetch(32'h10, NOP, 1'b0);

        // 2: two full words, back-to-back readback
        pbuf = '{8'h33, 8'h03, 8'h94, 8'h00, 8'hB3, 8'h03, 8'h39, 8'h41};
        load_buf();
        v0 = n_valid;
        do_fetch(32'h0, 32'h0094_0333, 1'b0);
        do_fetch(32'h4, 32'h4139_03B3, 1'b0);
        tick();
        check("back_to_back_valids", 32'(n_valid - v0), 32'd2);

        // 3: partial word is zero-filled on flush
        pbuf = '{8'h13, 8'h85, 8'h50, 8'h00, 8'hAA};
        load_buf();
        check("prog_err_partial", 32'(prog_err), 32'd0);
        do_fetch(32'h0, 32'h0050_8513, 1'b0);
        do_fetch(32'h4, 32'h0000_00AA, 1'b0);

        // 4: alignment and range faults
        do_fetch(32'h2, NOP, 1'b1);
        do_fetch(32'(DEPTH * 4), NOP, 1'b1);
        do_fetch(32'(DEPTH * 4 - 4), NOP, 1'b0);
        do_fetch(32'hFFFF_FFFC, NOP, 1'b1);

        // 5: overflow session
        pbuf.delete();
        for (int i = 0; i < DEPTH * 4 + 3; i++) pbuf.push_back(8'(i));
        load_buf();
        check("prog_ready_never_low", 32'(rdy_low), 32'd0);
        check("prog_err_overflow", 32'(prog_err), 32'd1);
        do_fetch(32'(DEPTH * 4 - 4), 32'hFFFE_FDFC, 1'b0);
        do_fetch(32'h0, 32'h0302_0100, 1'b0);
        do_fetch(32'h8, 32'h0B0A_0908, 1'b0);

        // 6: fetch ignored during LOAD, reset mid-session refills with NOP
        wait_ready();
        prog_en = 1'b1;
        tick();
        check("prog_err_cleared_new", 32'(prog_err), 32'd0);
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1'b1;
            prog_byte  = 8'hC0 + 8'(i);
            tick();
        end
        fetch_req  = 1'b0;
        prog_valid = 1'b0;
        prog_en    = 1'b0;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_load_ready", 32'(fetch_ready), 32'd0);
        clear_wait();
        do_fetch(32'h0, NOP, 1'b0);
        do_fetch(32'h4, NOP, 1'b0);
        do_fetch(32'(DEPTH * 4 - 4), NOP, 1'b0);

        tick();
        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
